// File: rtl/wb_irq_pkg.sv
// Shared constants for the Wishbone interrupt controller: register offsets
// (word index taken from ADR_I[4:2]) and the source-count bounds check.
package wb_irq_pkg;

  localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_REG_EDGESEL = 3'd2;
  localparam logic [2:0] IRQ_REG_CLAIM   = 3'd3;
  localparam logic [2:0] IRQ_REG_RAW     = 3'd4;
  localparam logic [2:0] IRQ_REG_SWSET   = 3'd5;

  localparam int IRQ_MAX_SRC = 32;

  // Every source must map onto one bit of the 32-bit data bus.
  function automatic bit num_src_ok(input int n);
    return (n >= 1) && (n <= IRQ_MAX_SRC);
  endfunction

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// Wishbone classic bus bundle between the core data port and the controller.
// Handshake: the slave accepts a request in any cycle where CYC_I & STB_I are
// high and ACK_O is low; ACK_O is then high for exactly one cycle with DAT_O
// valid, and the master must present a new request (or keep STB_I high) after
// that cycle to start the next access.
interface wb_irq_ctrl_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
                  input  DAT_O, ACK_O);
  modport slave  (input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
                  output DAT_O, ACK_O);
endinterface

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: SYNC_STAGES-flop synchroniser followed by a
// history flop. The history flop doubles as the registered level output, and
// the rise pulse is registered alongside it so both arrive together.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;

  // Shift the raw line in, remember the previous synced value, flag 0->1.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Synchroniser, history and rise flops, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Platform interrupt controller: latches synchronised sources as level or
// rising-edge pending bits, masks them onto irq_o and exposes the
// registers to the core over a Wishbone classic slave port.
module wb_irq_ctrl
  import wb_irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  wb_irq_ctrl_if.slave       wb,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic [NUM_SRC-1:0] irq_o
);

  if (!num_src_ok(NUM_SRC)) begin : g_bad_num_src
    $error("wb_irq_ctrl: NUM_SRC must be within 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("wb_irq_ctrl: SYNC_STAGES must be at least 2");
  end

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] irq_q, irq_d;

  logic [NUM_SRC-1:0] level, rise, wmask, wdata;
  logic [NUM_SRC-1:0] active, claim_onehot, rsrc;
  logic [NUM_SRC-1:0] w1c, sws, clm;
  logic [5:0]         claim_val;
  logic [31:0]        rdata;
  logic [2:0]         adr;
  logic               req, wr, rd;

  // Per-source synchroniser plus byte-lane write mask and masked write data.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (CLK_I),
      .rst     (RST_I),
      .d_i     (irq_src_i[g]),
      .level_o (level[g]),
      .rise_o  (rise[g])
    );
    assign wmask[g] = wb.SEL_I[g / 8];
    assign wdata[g] = wb.DAT_I[g] & wb.SEL_I[g / 8];
  end

  // Lowest-numbered enabled pending source wins the claim.
  always_comb begin
    active       = pending_q & enable_q;
    claim_onehot = '0;
    claim_val    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_onehot    = '0;
        claim_onehot[i] = 1'b1;
        claim_val       = 6'(i + 1);
      end
    end
  end

  // Bus decode and read mux; reads see register values before this cycle's update.
  always_comb begin
    req = wb.CYC_I & wb.STB_I & ~ack_q;
    wr  = req & wb.WE_I;
    rd  = req & ~wb.WE_I;
    adr = wb.ADR_I[4:2];
    case (adr)
      IRQ_REG_PENDING: rsrc = pending_q;
      IRQ_REG_ENABLE:  rsrc = enable_q;
      IRQ_REG_EDGESEL: rsrc = edge_sel_q;
      IRQ_REG_RAW:     rsrc = level;
      default:         rsrc = '0;
    endcase
    rdata = '0;
    for (int i = 0; i < NUM_SRC; i++) rdata[i] = rsrc[i];
    if (adr == IRQ_REG_CLAIM) rdata = {26'd0, claim_val};
    ack_d = req;
    dat_d = rd ? rdata : '0;
  end

  // Next state of control registers, pending bits and the irq output.
  always_comb begin
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    if (wr && adr == IRQ_REG_ENABLE)  enable_d   = (enable_q & ~wmask) | wdata;
    if (wr && adr == IRQ_REG_EDGESEL) edge_sel_d = (edge_sel_q & ~wmask) | wdata;
    w1c = (wr && adr == IRQ_REG_PENDING) ? wdata : '0;
    sws = (wr && adr == IRQ_REG_SWSET)   ? wdata : '0;
    clm = (rd && adr == IRQ_REG_CLAIM)   ? claim_onehot : '0;
    // Edge bits: set beats clear. Level bits simply track the synced input.
    pending_d = (edge_sel_q & ((rise | sws) | (pending_q & ~(w1c | clm))))
              | (~edge_sel_q & level);
    irq_d     = pending_q & enable_q;
  end

  // All architectural state, synchronous active-high reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      irq_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      irq_q      <= irq_d;
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = dat_q;
  assign irq_o    = irq_q;

  // Address bits outside [4:2], data bits and byte lanes above NUM_SRC are don't-care.
  logic unused_bits;
  assign unused_bits = ^{wb.ADR_I, wb.DAT_I, wb.SEL_I};

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Bench for wb_irq_ctrl: directed scenarios followed by random bus traffic and
// random source toggling, all checked against a rule-level reference model.
module tb_wb_irq_ctrl;

  localparam int N = 8;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src;
  logic [N-1:0] irq_o;
  logic         mon_en = 1'b0;

  always #5 clk = ~clk;

  wb_irq_ctrl_if bus ();

  wb_irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .wb        (bus),
    .irq_src_i (src),
    .irq_o     (irq_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[j] holds the source sample taken j+1 edges ago; a source sampled
  // high at edge k reaches pending at edge k+S+1 and irq_o at edge k+S+2.
  logic [N-1:0] hist [0:S+1];
  logic [N-1:0] m_pend, m_en, m_es, m_irq;
  logic         m_ack;
  logic [32:0]  exp_q[$];   // bit 32: access was a read, [31:0]: expected DAT_O

  always @(posedge clk) begin : model
    logic         req, we, set, clr;
    logic [2:0]   a;
    logic [N-1:0] wd, lvl, rse, nxt;
    logic [31:0]  rv;
    int           cv;
    if (rst) begin
      m_pend = '0; m_en = '0; m_es = '0; m_irq = '0; m_ack = 1'b0;
      for (int j = 0; j <= S + 1; j++) hist[j] = '0;
      exp_q.delete();
    end else begin
      req = bus.CYC_I && bus.STB_I && !m_ack;
      we  = bus.WE_I;
      a   = bus.ADR_I[4:2];
      wd  = bus.SEL_I[0] ? bus.DAT_I[N-1:0] : '0;
      lvl = hist[S];
      rse = hist[S] & ~hist[S+1];
      cv  = 0;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) cv = i + 1;
      if (req) begin
        if (we) exp_q.push_back({1'b0, 32'h0});
        else begin
          case (a)
            3'd0:    rv = {24'h0, m_pend};
            3'd1:    rv = {24'h0, m_en};
            3'd2:    rv = {24'h0, m_es};
            3'd3:    rv = 32'(cv);
            3'd4:    rv = {24'h0, lvl};
            default: rv = 32'h0;
          endcase
          exp_q.push_back({1'b1, rv});
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!m_es[i]) nxt[i] = lvl[i];
        else begin
          set    = rse[i] || (req && we && a == 3'd5 && wd[i]);
          clr    = (req && we && a == 3'd0 && wd[i]) || (req && !we && a == 3'd3 && cv == i + 1);
          nxt[i] = set || (m_pend[i] && !clr);
        end
      end
      m_irq = m_pend & m_en;
      if (req && we && a == 3'd1 && bus.SEL_I[0]) m_en = bus.DAT_I[N-1:0];
      if (req && we && a == 3'd2 && bus.SEL_I[0]) m_es = bus.DAT_I[N-1:0];
      m_pend = nxt;
      m_ack  = req;
      for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = src;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (mon_en) begin
      chk("ack", 32'(bus.ACK_O), 32'(m_ack));
      chk("irq", 32'(irq_o), 32'(m_irq));
      if (bus.ACK_O === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ack_unexpected: got ACK_O=1 want no access outstanding at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) chk("rdata", bus.DAT_O, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic w, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s);
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = w;
    bus.ADR_I = adr;  bus.DAT_I = d;    bus.SEL_I = s;
  endtask

  task automatic drop_req();
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); drive_req(1'b1, {27'd0, a, 2'b00}, d, s);
    @(negedge clk); drop_req();
  endtask

  task automatic wb_read_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk); drive_req(1'b0, {27'd0, a, 2'b00}, $urandom, 4'hF);
    @(negedge clk);
    chk({name, "_ack"}, 32'(bus.ACK_O), 32'd1);
    chk(name, bus.DAT_O, exp);
    drop_req();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    src = '1;
    drop_req();
    bus.ADR_I = '0; bus.DAT_I = '0; bus.SEL_I = '0;
    @(posedge clk);
    mon_en = 1'b1;

    // 1. reset with all sources high
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_ack", 32'(bus.ACK_O), 32'h0);
    chk("rst_dat", bus.DAT_O, 32'h0);
    rst = 1'b0;
    wb_read_chk(3'd0, 32'h0, "rst_pending");
    src = '0;
    repeat (S + 4) @(negedge clk);

    // 2. edge latch on source 2
    wb_write(3'd1, 32'h04, 4'hF);
    wb_write(3'd2, 32'h04, 4'hF);
    @(negedge clk); src = 8'h04;
    @(negedge clk); src = 8'h00;
    repeat (S + 1) @(negedge clk);
    chk("edge_irq_early", 32'(irq_o), 32'h0);
    @(negedge clk);
    chk("edge_irq_on", 32'(irq_o), 32'h04);
    repeat (3) @(negedge clk);
    chk("edge_irq_hold", 32'(irq_o), 32'h04);
    wb_read_chk(3'd3, 32'd3, "edge_claim");
    @(negedge clk);
    chk("edge_irq_off", 32'(irq_o), 32'h0);

    // 3. level mode on source 0
    wb_write(3'd2, 32'h00, 4'hF);
    wb_write(3'd1, 32'h01, 4'hF);
    @(negedge clk); src = 8'h01;
    repeat (S + 3) @(negedge clk);
    chk("lvl_irq_on", 32'(irq_o), 32'h01);
    wb_write(3'd0, 32'h01, 4'hF);
    repeat (2) @(negedge clk);
    chk("lvl_w1c_noeffect", 32'(irq_o), 32'h01);
    @(negedge clk); src = 8'h00;
    repeat (S + 2) @(negedge clk);
    chk("lvl_irq_late", 32'(irq_o), 32'h01);
    @(negedge clk);
    chk("lvl_irq_off", 32'(irq_o), 32'h00);

    // 4. W1C colliding with the synced edge of source 5
    wb_write(3'd2, 32'h20, 4'hF);
    wb_write(3'd1, 32'h20, 4'hF);
    @(negedge clk); src = 8'h20;
    repeat (S) @(negedge clk);
    wb_write(3'd0, 32'h20, 4'hF);
    wb_read_chk(3'd0, 32'h20, "collide_pending");
    wb_write(3'd0, 32'h20, 4'hF);
    wb_read_chk(3'd0, 32'h00, "w1c_pending");
    src = 8'h00;
    repeat (S + 3) @(negedge clk);

    // 5. claim priority, with STB held so accesses go every other cycle
    wb_write(3'd2, 32'hFF, 4'hF);
    wb_write(3'd1, 32'hFF, 4'hF);
    wb_write(3'd0, 32'hFF, 4'hF);
    wb_write(3'd5, 32'hA0, 4'h1);
    wb_read_chk(3'd0, 32'hA0, "prio_pending");
    @(negedge clk); drive_req(1'b0, 32'h0C, 32'h0, 4'hF);
    @(negedge clk); chk("prio_ack1", 32'(bus.ACK_O), 32'd1); chk("prio_claim1", bus.DAT_O, 32'd6);
    @(negedge clk); chk("prio_gap1", 32'(bus.ACK_O), 32'd0);
    @(negedge clk); chk("prio_ack2", 32'(bus.ACK_O), 32'd1); chk("prio_claim2", bus.DAT_O, 32'd8);
    @(negedge clk); chk("prio_gap2", 32'(bus.ACK_O), 32'd0);
    @(negedge clk); chk("prio_ack3", 32'(bus.ACK_O), 32'd1); chk("prio_claim3", bus.DAT_O, 32'd0);
    drop_req();

    // 6. SWSET with byte enables, reserved offsets, masked enable write, RAW
    wb_write(3'd0, 32'hFF, 4'hF);
    wb_write(3'd5, 32'h0000_0102, 4'b0001);
    wb_read_chk(3'd0, 32'h02, "swset_pending");
    wb_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    wb_read_chk(3'd6, 32'h0, "reserved_read");
    wb_read_chk(3'd5, 32'h0, "swset_read");
    wb_write(3'd1, 32'h0000_FF00, 4'b0010);
    wb_read_chk(3'd1, 32'hFF, "enable_sel_masked");
    @(negedge clk); src = 8'h3C;
    repeat (S + 3) @(negedge clk);
    wb_read_chk(3'd4, 32'h3C, "raw_read");

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) src = 8'($urandom);
      @(negedge clk);
      drive_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        @(negedge clk); drop_req();
      end else begin
        repeat (2) @(negedge clk); drop_req();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
